// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for pulse_stretch: FSM state encoding and a width helper.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } ps_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretch_timer.sv
// Loadable down-counter shared by the ON and OFF phases; holds at zero.
module pulse_stretch_timer #(
    parameter int W = 4
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into visible pulses of fixed high/low time.
// Define PULSE_STRETCH_QUEUE_EN to queue events that arrive while busy.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int on_time     = 100000,
    parameter int off_time    = 100000,
    parameter int queue_depth = 7
) (
    input  logic      CLOCK,
    input  logic      RESET,
    input  logic      EVENT_IN,
    output logic      SIGNAL_OUT,
    output logic      BUSY,
    output logic      OVERFLOW,
    output ps_state_e state_dbg
);

    localparam int TW = $clog2(max_int(on_time, off_time)) + 1;
    localparam logic [TW-1:0] ON_LOAD  = TW'(on_time - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(off_time - 1);

    ps_state_e     state;
    logic          event_d;
    logic          event_pulse;
    logic          timer_zero;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          start_pulse;
    logic          end_on;
    logic          drop;

`ifdef PULSE_STRETCH_QUEUE_EN
    localparam int PW = $clog2(queue_depth + 1);
    localparam logic [PW-1:0] QMAX = PW'(queue_depth);

    logic [PW-1:0] pending;
    logic [PW-1:0] pending_nxt;
`endif

    always_comb begin
        event_pulse = EVENT_IN & ~event_d;
        end_on      = (state == ST_ON) && timer_zero;
        start_pulse = 1'b0;
        drop        = 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
        pending_nxt = pending;
        case (state)
            ST_IDLE: begin
                if (event_pulse) begin
                    start_pulse = 1'b1;
                end else if (pending != '0) begin
                    start_pulse = 1'b1;
                    pending_nxt = pending - 1'b1;
                end
            end
            ST_OFF: begin
                // In the final OFF cycle a new event and a dequeue cancel out.
                if (timer_zero) begin
                    if (event_pulse) begin
                        start_pulse = 1'b1;
                    end else if (pending != '0) begin
                        start_pulse = 1'b1;
                        pending_nxt = pending - 1'b1;
                    end
                end else if (event_pulse) begin
                    if (pending < QMAX) pending_nxt = pending + 1'b1;
                    else                drop        = 1'b1;
                end
            end
            ST_ON: begin
                if (event_pulse) begin
                    if (pending < QMAX) pending_nxt = pending + 1'b1;
                    else                drop        = 1'b1;
                end
            end
            default: ;
        endcase
`else
        case (state)
            ST_IDLE: start_pulse = event_pulse;
            ST_ON,
            ST_OFF:  drop        = event_pulse;
            default: ;
        endcase
`endif
        timer_load = start_pulse || end_on;
        timer_val  = end_on ? OFF_LOAD : ON_LOAD;
    end

    pulse_stretch_timer #(
        .W(TW)
    ) u_timer (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            SIGNAL_OUT <= 1'b0;
            OVERFLOW   <= 1'b0;
            event_d    <= 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
            pending    <= '0;
`endif
        end else begin
            event_d  <= EVENT_IN;
            OVERFLOW <= drop;
`ifdef PULSE_STRETCH_QUEUE_EN
            pending  <= pending_nxt;
`endif
            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state      <= ST_ON;
                        SIGNAL_OUT <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (timer_zero) begin
                        state      <= ST_OFF;
                        SIGNAL_OUT <= 1'b0;
                    end
                end
                ST_OFF: begin
                    if (timer_zero) begin
                        if (start_pulse) begin
                            state      <= ST_ON;
                            SIGNAL_OUT <= 1'b1;
                        end else begin
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    SIGNAL_OUT <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule
